// File: rtl/inst_fetch.sv
// Instruction fetch: PC, imem req/ack, one instruction per FETCH+HOLD (ack in first FETCH -> inst_valid next cycle).
// Backpressure: stall holds HOLD (no request); redirects during a pending request wait for its ack.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [31:0] redirect_al;

  assign redirect_al = redirect_pc & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC_AL;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (redir_pend_q || redirect) begin
            // Word fetched from the old path is dropped; a same-cycle redirect is the latest target.
            pc_d         = redirect ? redirect_al : redir_tgt_q;
            redir_pend_d = 1'b0;
          end else begin
            inst_d       = imem_rdata;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = redirect_al;
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_d         = redirect ? redirect_al : pc_q + 32'd4;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table of fetch transactions plus hand sequences for redirect/wrap/reset corners.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  inst_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          wait_c;
    int          stall_c;
    logic        redir;
    logic [31:0] tgt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  vec_t vecs[6];
  sb_t  exp_q[$];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ack one word now and record what decode should later see.
  task automatic ack_word(input logic [31:0] addr);
    sb_t e;
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    e.pc       = addr;
    e.inst     = imem_rdata;
    exp_q.push_back(e);
    step();
    imem_ack = 1'b0;
  endtask

  task automatic hold_check();
    sb_t e;
    chk("hold_valid", {31'b0, inst_valid}, 32'd1);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("hold_inst", inst, e.inst);
      chk("hold_pc", pc, e.pc);
      chk("hold_pc4", pc_plus4, e.pc + 32'd4);
    end
  endtask

  initial begin
    logic [31:0] held_inst;
    logic [31:0] held_pc;

    vecs[0] = '{addr: 32'h0,   wait_c: 0, stall_c: 0, redir: 1'b0, tgt: 32'h0};
    vecs[1] = '{addr: 32'h4,   wait_c: 0, stall_c: 0, redir: 1'b0, tgt: 32'h0};
    vecs[2] = '{addr: 32'h8,   wait_c: 0, stall_c: 0, redir: 1'b0, tgt: 32'h0};
    vecs[3] = '{addr: 32'hC,   wait_c: 3, stall_c: 5, redir: 1'b0, tgt: 32'h0};
    vecs[4] = '{addr: 32'h10,  wait_c: 0, stall_c: 0, redir: 1'b1, tgt: 32'h103};
    vecs[5] = '{addr: 32'h100, wait_c: 1, stall_c: 1, redir: 1'b1, tgt: 32'h20};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #12;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_pc4", pc_plus4, 32'h4);

    step();
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    step();

    for (int i = 0; i < 6; i++) begin
      chk("fetch_req", {31'b0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, vecs[i].addr);
      chk("fetch_valid", {31'b0, inst_valid}, 32'd0);
      for (int w = 0; w < vecs[i].wait_c; w++) begin
        step();
        chk("wait_req", {31'b0, imem_req}, 32'd1);
        chk("wait_addr", imem_addr, vecs[i].addr);
        chk("wait_valid", {31'b0, inst_valid}, 32'd0);
      end
      ack_word(vecs[i].addr);
      held_inst = inst;
      held_pc   = pc;
      hold_check();
      // Stalled HOLD: stray ack and redirect must both be ignored.
      for (int s = 0; s < vecs[i].stall_c; s++) begin
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h999;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        chk("stall_inst", inst, held_inst);
        chk("stall_pc", pc, held_pc);
        chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_req", {31'b0, imem_req}, 32'd0);
      end
      imem_ack = 1'b0; stall = 1'b0;
      redirect = vecs[i].redir; redirect_pc = vecs[i].tgt;
      step();
      redirect = 1'b0;
    end

    // Redirects while a request waits: address holds, last target wins.
    chk("pend_addr0", imem_addr, 32'h20);
    redirect = 1'b1; redirect_pc = 32'h30;
    step();
    chk("pend_addr1", imem_addr, 32'h20);
    chk("pend_req1", {31'b0, imem_req}, 32'd1);
    redirect_pc = 32'h41;
    step();
    chk("pend_addr2", imem_addr, 32'h20);
    redirect = 1'b0;
    step();
    chk("pend_addr3", imem_addr, 32'h20);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("discard_valid", {31'b0, inst_valid}, 32'd0);
    chk("discard_req", {31'b0, imem_req}, 32'd1);
    chk("discard_addr", imem_addr, 32'h40);
    ack_word(32'h40);
    hold_check();

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    ack_word(32'hFFFF_FFFC);
    hold_check();
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", {31'b0, imem_req}, 32'd1);

    step();
    chk("mid_req", {31'b0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, inst_valid}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
